// File: rtl/sifive_scope_pkg.sv
// Shared types for the hart 0 dcache-request scope: command enum, trace record, header layout.
package sifive_scope_pkg;

    typedef enum logic [4:0] {
        M_XRD       = 5'd0,
        M_XWR       = 5'd1,
        M_PFR       = 5'd2,
        M_PFW       = 5'd3,
        M_XA_SWAP   = 5'd4,
        M_FLUSH_ALL = 5'd5,
        M_XLR       = 5'd6,
        M_XSC       = 5'd7,
        M_XA_ADD    = 5'd8,
        M_XA_XOR    = 5'd9,
        M_XA_OR     = 5'd10,
        M_XA_AND    = 5'd11,
        M_XA_MIN    = 5'd12,
        M_XA_MAX    = 5'd13,
        M_XA_MINU   = 5'd14,
        M_XA_MAXU   = 5'd15,
        M_FLUSH     = 5'd16,
        M_PWR       = 5'd17,
        M_PRODUCE   = 5'd18,
        M_CLEAN     = 5'd19,
        M_SFENCE    = 5'd20
    } dcache_cmd_e;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } ser_state_e;

    typedef struct packed {
        dcache_cmd_e cmd;
        logic [6:0]  id;
        logic [3:0]  wmask;
        logic        signd;
        logic [1:0]  size;
        logic        has_data;
        logic        ovf;
        logic [10:0] ts;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dcache_trace_rec_t;

    localparam int HDR_CMD_LSB      = 27;
    localparam int HDR_ID_LSB       = 20;
    localparam int HDR_WMASK_LSB    = 16;
    localparam int HDR_SIGNED_BIT   = 15;
    localparam int HDR_SIZE_LSB     = 13;
    localparam int HDR_HAS_DATA_BIT = 12;
    localparam int HDR_OVF_BIT      = 11;
    localparam int HDR_TS_LSB       = 0;

    function automatic logic [31:0] rec_header(input dcache_trace_rec_t rec);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_CMD_LSB +: 5]     = rec.cmd;
        hdr[HDR_ID_LSB +: 7]      = rec.id;
        hdr[HDR_WMASK_LSB +: 4]   = rec.wmask;
        hdr[HDR_SIGNED_BIT]       = rec.signd;
        hdr[HDR_SIZE_LSB +: 2]    = rec.size;
        hdr[HDR_HAS_DATA_BIT]     = rec.has_data;
        hdr[HDR_OVF_BIT]          = rec.ovf;
        hdr[HDR_TS_LSB +: 11]     = rec.ts;
        return hdr;
    endfunction

endpackage

// File: rtl/sifive_scope_rec_fifo.sv
// DEPTH-entry trace record FIFO; the head record is read combinationally so the
// serializer can present it the cycle after it was written.
module sifive_scope_rec_fifo
    import sifive_scope_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      push,
    input  dcache_trace_rec_t         push_rec,
    input  logic                      pop,
    output dcache_trace_rec_t         head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    dcache_trace_rec_t mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_rec;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/sifive_scope_dcache_req_capture.sv
// Hart 0 DCacheReq trace capture: filter, buffer whole records, serialize to 32-bit words.
// Define SIFIVE_SCOPE_DCACHE_REQ_TIMESTAMP_EN to stamp headers with an 11-bit cycle counter.
module sifive_scope_dcache_req_capture
    import sifive_scope_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] cmd_filter,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    input  logic [6:0]  req_id,
    input  logic [4:0]  req_cmd,
    input  logic        req_signed,
    input  logic [1:0]  req_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] drop_count,
    input  logic        drop_clear
);
    localparam int AW = $clog2(DEPTH);

    dcache_trace_rec_t new_rec;
    dcache_trace_rec_t head_rec;
    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              evt;
    logic              push;
    logic              drop;
    logic              pop;
    logic              rec_last;
    logic              pend_ovf_reg;
    logic [15:0]       drop_count_reg;
    logic [10:0]       ts_now;
    ser_state_e        state_reg;
    ser_state_e        state_next;

`ifdef SIFIVE_SCOPE_DCACHE_REQ_TIMESTAMP_EN
    logic [10:0] ts_reg;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts_reg <= '0;
        else          ts_reg <= ts_reg + 11'd1;
    end
    assign ts_now = ts_reg;
`else
    assign ts_now = '0;
`endif

    // Space is judged on the registered count only; a same-cycle pop never makes room.
    assign evt  = req_valid && enable && cmd_filter[req_cmd];
    assign push = evt && (fifo_count < (AW+1)'(DEPTH));
    assign drop = evt && fifo_full;

    always_comb begin
        new_rec          = '0;
        new_rec.cmd      = dcache_cmd_e'(req_cmd);
        new_rec.id       = req_id;
        new_rec.wmask    = req_wmask;
        new_rec.signd    = req_signed;
        new_rec.size     = req_size;
        new_rec.has_data = (req_wmask != 4'd0);
        new_rec.ovf      = pend_ovf_reg;
        new_rec.ts       = ts_now;
        new_rec.addr     = req_addr;
        new_rec.wdata    = req_wdata;
    end

    sifive_scope_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_rec (new_rec),
        .pop      (pop),
        .head     (head_rec),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // drop_clear takes priority over a coincident drop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_reg <= '0;
            pend_ovf_reg   <= 1'b0;
        end else if (drop_clear) begin
            drop_count_reg <= '0;
            pend_ovf_reg   <= 1'b0;
        end else if (drop) begin
            if (drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
            pend_ovf_reg <= 1'b1;
        end else if (push) begin
            pend_ovf_reg <= 1'b0;
        end
    end
    assign drop_count = drop_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_HDR;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (out_valid && out_ready) begin
            unique case (state_reg)
                ST_HDR:  state_next = ST_ADDR;
                ST_ADDR: state_next = head_rec.has_data ? ST_DATA : ST_HDR;
                ST_DATA: state_next = ST_HDR;
                default: state_next = ST_HDR;
            endcase
        end
    end

    always_comb begin
        out_valid = !fifo_empty;
        out_data  = '0;
        rec_last  = 1'b0;
        if (!fifo_empty) begin
            unique case (state_reg)
                ST_HDR:  out_data = rec_header(head_rec);
                ST_ADDR: begin
                    out_data = head_rec.addr;
                    rec_last = !head_rec.has_data;
                end
                ST_DATA: begin
                    out_data = head_rec.wdata;
                    rec_last = 1'b1;
                end
                default: out_data = '0;
            endcase
        end
    end

    assign pop = out_valid && out_ready && rec_last;

endmodule
